branch_predictor: RTL and testbench

Fetch-stage dynamic branch predictor for the RV32I 5-stage pipeline. It sits upstream of the IF/ID register and the decode controller. It looks up the fetch PC in a direct-mapped branch target buffer (BTB) with 2-bit saturating counters and supplies a predicted next PC. It is trained from the EX stage using the pipelined `branch`/`jumpsel` decode results and the resolved outcome, and it flags mispredictions together with the corrective redirect PC.

---
 rtl/branch_predictor.sv | 135 +++++++++++++
 tb/tb_branch_predictor.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Fetch-stage dynamic branch predictor: direct-mapped BTB with 2-bit saturating
// counters, trained from EX, with misprediction detection and perf counters.
module branch_predictor #(
    parameter int INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_f,
    output logic        predict_taken_f,
    output logic [31:0] predict_pc_f,
    input  logic        update_valid_e,
    input  logic [31:0] pc_e,
    input  logic        branch_e,
    input  logic        jump_e,
    input  logic        taken_e,
    input  logic [31:0] target_e,
    input  logic        pred_taken_e,
    input  logic [31:0] pred_pc_e,
    output logic        mispredict_e,
    output logic [31:0] redirect_pc_e,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    localparam int ENTRIES  = 1 << INDEX_BITS;
    localparam int TAG_BITS = 30 - INDEX_BITS;

    logic [ENTRIES-1:0]  valid_q;
    logic [ENTRIES-1:0]  is_jump_q;
    logic [1:0]          ctr_q    [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];

    logic [INDEX_BITS-1:0] idx_f, idx_e;
    logic [TAG_BITS-1:0]   tag_f, tag_e;
    logic                  hit_f, hit_e;
    logic                  is_cti_e;
    logic [1:0]            ctr_e, ctr_inc_e, ctr_dec_e;
    logic                  unused_pc_lsbs;

    assign unused_pc_lsbs = ^{pc_f[1:0], pc_e[1:0]};

    assign idx_f = pc_f[INDEX_BITS+1:2];
    assign tag_f = pc_f[31:INDEX_BITS+2];
    assign idx_e = pc_e[INDEX_BITS+1:2];
    assign tag_e = pc_e[31:INDEX_BITS+2];

    // Lookup reads only registered state, so a same-cycle update is never bypassed.
    assign hit_f           = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign predict_taken_f = hit_f && (is_jump_q[idx_f] || ctr_q[idx_f][1]);
    assign predict_pc_f    = predict_taken_f ? target_q[idx_f] : pc_f + 32'd4;

    assign hit_e     = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    assign is_cti_e  = branch_e || jump_e;
    assign ctr_e     = ctr_q[idx_e];
    assign ctr_inc_e = (ctr_e == 2'b11) ? 2'b11 : ctr_e + 2'd1;
    assign ctr_dec_e = (ctr_e == 2'b00) ? 2'b00 : ctr_e - 2'd1;

    always_comb begin
        mispredict_e  = 1'b0;
        redirect_pc_e = pc_e + 32'd4;
        if (update_valid_e) begin
            if (is_cti_e) begin
                mispredict_e = (pred_taken_e != taken_e) ||
                               (taken_e && (pred_pc_e != target_e));
                if (taken_e) begin
                    redirect_pc_e = target_e;
                end
            end else begin
                // A predicted-taken non-branch means the entry is stale.
                mispredict_e = pred_taken_e;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= 2'b01;
            end
        end else if (update_valid_e) begin
            if (jump_e) begin
                valid_q[idx_e] <= 1'b1;
                ctr_q[idx_e]   <= 2'b11;
            end else if (branch_e) begin
                if (hit_e) begin
                    ctr_q[idx_e] <= taken_e ? ctr_inc_e : ctr_dec_e;
                end else if (taken_e) begin
                    valid_q[idx_e] <= 1'b1;
                    ctr_q[idx_e]   <= 2'b10;
                end
            end else if (hit_e) begin
                valid_q[idx_e] <= 1'b0;
            end
        end
    end

    // Payload fields are only meaningful while valid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (update_valid_e) begin
            if (jump_e) begin
                tag_q[idx_e]     <= tag_e;
                target_q[idx_e]  <= target_e;
                is_jump_q[idx_e] <= 1'b1;
            end else if (branch_e) begin
                if (hit_e) begin
                    is_jump_q[idx_e] <= 1'b0;
                    if (taken_e) begin
                        target_q[idx_e] <= target_e;
                    end
                end else if (taken_e) begin
                    tag_q[idx_e]     <= tag_e;
                    target_q[idx_e]  <= target_e;
                    is_jump_q[idx_e] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (update_valid_e && is_cti_e && (branch_count != 32'hFFFF_FFFF)) begin
                branch_count <= branch_count + 32'd1;
            end
            if (mispredict_e && (mispredict_count != 32'hFFFF_FFFF)) begin
                mispredict_count <= mispredict_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor with hand-computed
// expectations for prediction, training, resolution and the perf counters.
module tb_branch_predictor;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_f;
    logic        predict_taken_f;
    logic [31:0] predict_pc_f;
    logic        update_valid_e;
    logic [31:0] pc_e;
    logic        branch_e;
    logic        jump_e;
    logic        taken_e;
    logic [31:0] target_e;
    logic        pred_taken_e;
    logic [31:0] pred_pc_e;
    logic        mispredict_e;
    logic [31:0] redirect_pc_e;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    int total = 0;
    int bad   = 0;

    branch_predictor #(.INDEX_BITS(6)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pc_f             (pc_f),
        .predict_taken_f  (predict_taken_f),
        .predict_pc_f     (predict_pc_f),
        .update_valid_e   (update_valid_e),
        .pc_e             (pc_e),
        .branch_e         (branch_e),
        .jump_e           (jump_e),
        .taken_e          (taken_e),
        .target_e         (target_e),
        .pred_taken_e     (pred_taken_e),
        .pred_pc_e        (pred_pc_e),
        .mispredict_e     (mispredict_e),
        .redirect_pc_e    (redirect_pc_e),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1ns after a rising edge; outputs are checked 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        update_valid_e = 1'b0;
        pc_e = 32'h0; branch_e = 1'b0; jump_e = 1'b0; taken_e = 1'b0;
        target_e = 32'h0; pred_taken_e = 1'b0; pred_pc_e = 32'h0;
    endtask

    task automatic set_upd(input logic [31:0] pc, input logic br, input logic jmp,
                           input logic tk, input logic [31:0] tgt,
                           input logic ptk, input logic [31:0] ppc);
        update_valid_e = 1'b1;
        pc_e = pc; branch_e = br; jump_e = jmp; taken_e = tk;
        target_e = tgt; pred_taken_e = ptk; pred_pc_e = ppc;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        pc_f  = 32'h100;
        pc_e  = 32'h300;
        pred_taken_e = 1'b1;
        #2;
        total++; if (predict_taken_f !== 1'b0) begin bad++; $display("[TB] FAIL reset_pred_taken got=%0h want=0", predict_taken_f); end
        total++; if (predict_pc_f !== 32'h104) begin bad++; $display("[TB] FAIL reset_pred_pc got=%0h want=104", predict_pc_f); end
        total++; if (branch_count !== 32'h0) begin bad++; $display("[TB] FAIL reset_branch_count got=%0h want=0", branch_count); end
        total++; if (mispredict_count !== 32'h0) begin bad++; $display("[TB] FAIL reset_mispredict_count got=%0h want=0", mispredict_count); end
        total++; if (mispredict_e !== 1'b0) begin bad++; $display("[TB] FAIL reset_mispredict got=%0h want=0", mispredict_e); end
        total++; if (redirect_pc_e !== 32'h304) begin bad++; $display("[TB] FAIL reset_redirect got=%0h want=304", redirect_pc_e); end
        pc_f = 32'hFFFF_FFFC;
        #1;
        total++; if (predict_pc_f !== 32'h0) begin bad++; $display("[TB] FAIL pc_wrap got=%0h want=0", predict_pc_f); end
        rst_n = 1'b1;
        idle();
        tick();
    endtask

    task automatic test_cold_taken();
        do_reset();
        pc_f = 32'h100;
        set_upd(32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104);
        #1;
        total++; if (mispredict_e !== 1'b1) begin bad++; $display("[TB] FAIL cold_mispredict got=%0h want=1", mispredict_e); end
        total++; if (redirect_pc_e !== 32'h80) begin bad++; $display("[TB] FAIL cold_redirect got=%0h want=80", redirect_pc_e); end
        total++; if (predict_taken_f !== 1'b0) begin bad++; $display("[TB] FAIL cold_no_bypass got=%0h want=0", predict_taken_f); end
        tick();
        idle();
        #1;
        total++; if (predict_taken_f !== 1'b1) begin bad++; $display("[TB] FAIL cold_trained_taken got=%0h want=1", predict_taken_f); end
        total++; if (predict_pc_f !== 32'h80) begin bad++; $display("[TB] FAIL cold_trained_pc got=%0h want=80", predict_pc_f); end
        total++; if (branch_count !== 32'd1) begin bad++; $display("[TB] FAIL cold_branch_count got=%0d want=1", branch_count); end
        total++; if (mispredict_count !== 32'd1) begin bad++; $display("[TB] FAIL cold_mispredict_count got=%0d want=1", mispredict_count); end
    endtask

    // Continues from the entry at 0x100 left with ctr=10, target=0x80.
    task automatic test_hysteresis();
        pc_f = 32'h100;
        set_upd(32'h100, 1'b1, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80);
        tick(); idle(); #1;
        total++; if (predict_taken_f !== 1'b0) begin bad++; $display("[TB] FAIL hyst_nt1 got=%0h want=0", predict_taken_f); end
        set_upd(32'h100, 1'b1, 1'b0, 1'b0, 32'h80, 1'b0, 32'h104);
        #1;
        total++; if (mispredict_e !== 1'b0) begin bad++; $display("[TB] FAIL hyst_nt_correct got=%0h want=0", mispredict_e); end
        tick(); idle(); #1;
        total++; if (predict_pc_f !== 32'h104) begin bad++; $display("[TB] FAIL hyst_nt2_pc got=%0h want=104", predict_pc_f); end
        set_upd(32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104);
        tick(); idle(); #1;
        total++; if (predict_taken_f !== 1'b0) begin bad++; $display("[TB] FAIL hyst_t1 got=%0h want=0", predict_taken_f); end
        set_upd(32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104);
        tick(); idle(); #1;
        total++; if (predict_taken_f !== 1'b1) begin bad++; $display("[TB] FAIL hyst_t2 got=%0h want=1", predict_taken_f); end
        // Predicted taken with target 0x80 but resolves to 0x90.
        set_upd(32'h100, 1'b1, 1'b0, 1'b1, 32'h90, 1'b1, 32'h80);
        #1;
        total++; if (mispredict_e !== 1'b1) begin bad++; $display("[TB] FAIL hyst_wrong_target got=%0h want=1", mispredict_e); end
        tick(); idle(); #1;
        total++; if (predict_pc_f !== 32'h90) begin bad++; $display("[TB] FAIL hyst_t3_new_target got=%0h want=90", predict_pc_f); end
        set_upd(32'h100, 1'b1, 1'b0, 1'b1, 32'h90, 1'b1, 32'h90);
        tick();
        set_upd(32'h100, 1'b1, 1'b0, 1'b0, 32'h90, 1'b1, 32'h90);
        tick(); idle(); #1;
        total++; if (predict_taken_f !== 1'b1) begin bad++; $display("[TB] FAIL hyst_saturated got=%0h want=1", predict_taken_f); end
        set_upd(32'h100, 1'b1, 1'b0, 1'b0, 32'h90, 1'b1, 32'h90);
        tick(); idle(); #1;
        total++; if (predict_taken_f !== 1'b0) begin bad++; $display("[TB] FAIL hyst_weak_nt got=%0h want=0", predict_taken_f); end
    endtask

    task automatic test_jump();
        do_reset();
        pc_f = 32'h200;
        set_upd(32'h200, 1'b0, 1'b1, 1'b1, 32'h400, 1'b0, 32'h204);
        #1;
        total++; if (redirect_pc_e !== 32'h400) begin bad++; $display("[TB] FAIL jump_redirect got=%0h want=400", redirect_pc_e); end
        tick(); idle(); #1;
        total++; if (predict_pc_f !== 32'h400) begin bad++; $display("[TB] FAIL jump_pred_pc got=%0h want=400", predict_pc_f); end
        set_upd(32'h200, 1'b1, 1'b0, 1'b0, 32'h400, 1'b1, 32'h400);
        #1;
        total++; if (redirect_pc_e !== 32'h204) begin bad++; $display("[TB] FAIL jump_br_nt_redirect got=%0h want=204", redirect_pc_e); end
        tick(); idle(); #1;
        total++; if (predict_taken_f !== 1'b1) begin bad++; $display("[TB] FAIL jump_br_nt1 got=%0h want=1", predict_taken_f); end
        set_upd(32'h200, 1'b1, 1'b0, 1'b0, 32'h400, 1'b1, 32'h400);
        tick(); idle(); #1;
        total++; if (predict_taken_f !== 1'b0) begin bad++; $display("[TB] FAIL jump_br_nt2 got=%0h want=0", predict_taken_f); end
        // branch_e and jump_e together must train as a jump (ctr=11).
        set_upd(32'h200, 1'b1, 1'b1, 1'b1, 32'h500, 1'b0, 32'h204);
        tick();
        set_upd(32'h200, 1'b1, 1'b0, 1'b0, 32'h500, 1'b1, 32'h500);
        tick(); idle(); #1;
        total++; if (predict_pc_f !== 32'h500) begin bad++; $display("[TB] FAIL jump_precedence got=%0h want=500", predict_pc_f); end
    endtask

    task automatic test_alias();
        do_reset();
        set_upd(32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104);
        tick();
        set_upd(32'h200, 1'b1, 1'b0, 1'b1, 32'h600, 1'b0, 32'h204);
        tick(); idle();
        pc_f = 32'h100;
        #1;
        total++; if (predict_taken_f !== 1'b0) begin bad++; $display("[TB] FAIL alias_evicted got=%0h want=0", predict_taken_f); end
        total++; if (predict_pc_f !== 32'h104) begin bad++; $display("[TB] FAIL alias_evicted_pc got=%0h want=104", predict_pc_f); end
        pc_f = 32'h200;
        #1;
        total++; if (predict_pc_f !== 32'h600) begin bad++; $display("[TB] FAIL alias_new_pc got=%0h want=600", predict_pc_f); end
    endtask

    task automatic test_stale_counters();
        do_reset();
        pc_f = 32'h100;
        set_upd(32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104);
        tick();
        set_upd(32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h104);
        #1;
        total++; if (mispredict_e !== 1'b0) begin bad++; $display("[TB] FAIL plain_nonbranch got=%0h want=0", mispredict_e); end
        tick();
        idle();
        pred_taken_e = 1'b1;
        #1;
        total++; if (mispredict_e !== 1'b0) begin bad++; $display("[TB] FAIL gated_mispredict got=%0h want=0", mispredict_e); end
        tick();
        set_upd(32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80);
        #1;
        total++; if (mispredict_e !== 1'b1) begin bad++; $display("[TB] FAIL stale_mispredict got=%0h want=1", mispredict_e); end
        total++; if (redirect_pc_e !== 32'h104) begin bad++; $display("[TB] FAIL stale_redirect got=%0h want=104", redirect_pc_e); end
        tick(); idle(); #1;
        total++; if (predict_taken_f !== 1'b0) begin bad++; $display("[TB] FAIL stale_invalidated got=%0h want=0", predict_taken_f); end
        for (int i = 0; i < 9; i++) begin
            set_upd(32'h300 + 32'(i * 4), 1'b1, 1'b0, 1'b0, 32'h0, (i == 2 || i == 6), 32'h0);
            tick();
        end
        idle();
        #1;
        total++; if (branch_count !== 32'd10) begin bad++; $display("[TB] FAIL branch_count got=%0d want=10", branch_count); end
        total++; if (mispredict_count !== 32'd4) begin bad++; $display("[TB] FAIL mispredict_count got=%0d want=4", mispredict_count); end
    endtask

    task automatic test_async_reset();
        do_reset();
        pc_f = 32'h100;
        set_upd(32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104);
        tick(); idle(); #1;
        total++; if (predict_taken_f !== 1'b1) begin bad++; $display("[TB] FAIL async_pre got=%0h want=1", predict_taken_f); end
        #1;
        rst_n = 1'b0;
        #1;
        total++; if (predict_taken_f !== 1'b0) begin bad++; $display("[TB] FAIL async_cleared got=%0h want=0", predict_taken_f); end
        total++; if (branch_count !== 32'd0) begin bad++; $display("[TB] FAIL async_count got=%0d want=0", branch_count); end
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        pc_f  = 32'h0;
        idle();
        test_reset();
        test_cold_taken();
        test_hysteresis();
        test_jump();
        test_alias();
        test_stale_counters();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
